// File: rtl/unit_redirect_ctrl_pkg.sv
// Redirect controller shared definitions.
// State encoding, default widths and shadow-window length.
package unit_redirect_ctrl_pkg;

   localparam int REDIR_BUS_W      = 32;
   localparam int REDIR_SHADOW_CYC = 1;
   localparam int REDIR_CNT_W      = 3;

   typedef enum logic [1:0] {
      REDIR_IDLE   = 2'd0,
      REDIR_PEND   = 2'd1,
      REDIR_SHADOW = 2'd2
   } redir_state_e;

endpackage

// File: rtl/unit_redirect_ctrl_if.sv
// Redirect controller bundle: jump/trap requests, IF redirect
// handshake, flush/stall controls and misalign report.
// master: controller side; slave: pipeline/IF side.
interface unit_redirect_ctrl_if
   import unit_redirect_ctrl_pkg::*;
#(
   parameter int BUS_W = REDIR_BUS_W
);

   logic             jumpEn_in;
   logic [BUS_W-1:0] jumpAddr_in;
   logic             trapEn_in;
   logic [BUS_W-1:0] trapAddr_in;
   logic             redirReady_in;
   logic             redirValid_out;
   logic [BUS_W-1:0] redirAddr_out;
   logic             flushIF_out;
   logic             flushID_out;
   logic             idStall_out;
   logic             misalign_out;
   logic [BUS_W-1:0] misalignAddr_out;

   modport master (
      input  jumpEn_in,
      input  jumpAddr_in,
      input  trapEn_in,
      input  trapAddr_in,
      input  redirReady_in,
      output redirValid_out,
      output redirAddr_out,
      output flushIF_out,
      output flushID_out,
      output idStall_out,
      output misalign_out,
      output misalignAddr_out
   );

   modport slave (
      output jumpEn_in,
      output jumpAddr_in,
      output trapEn_in,
      output trapAddr_in,
      output redirReady_in,
      input  redirValid_out,
      input  redirAddr_out,
      input  flushIF_out,
      input  flushID_out,
      input  idStall_out,
      input  misalign_out,
      input  misalignAddr_out
   );

endinterface

// File: rtl/unit_redirect_ctrl.sv
// Sequences PC redirects (trap over jump) to IF with flush/stall
// pulses. Ports: clk_in, rst_in (sync, active high), bus (master).
module unit_redirect_ctrl
   import unit_redirect_ctrl_pkg::*;
#(
   parameter int BUS_W      = REDIR_BUS_W,
   parameter int SHADOW_CYC = REDIR_SHADOW_CYC
) (
   input logic                  clk_in,
   input logic                  rst_in,
   unit_redirect_ctrl_if.master bus
);

   localparam int CW = REDIR_CNT_W;

   redir_state_e     state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BUS_W-1:0] addr_q, addr_d;
   logic             fid_q, fid_d;
   logic             mis_q, mis_d;
   logic [BUS_W-1:0] maddr_q, maddr_d;

   logic             hs;
   logic [BUS_W-1:0] trap_tgt;
   logic [BUS_W-1:0] jump_tgt;

   assign hs       = (state_q == REDIR_PEND) & bus.redirReady_in;
   assign trap_tgt = {bus.trapAddr_in[BUS_W-1:1], 1'b0};
   assign jump_tgt = {bus.jumpAddr_in[BUS_W-1:1], 1'b0};

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= REDIR_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         fid_q   <= 1'b0;
         mis_q   <= 1'b0;
         maddr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         fid_q   <= fid_d;
         mis_q   <= mis_d;
         maddr_q <= maddr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      fid_d   = 1'b0;
      mis_d   = 1'b0;
      maddr_d = maddr_q;

      case (state_q)
         REDIR_IDLE: begin
            if (bus.trapEn_in) begin
               state_d = REDIR_PEND;
               addr_d  = trap_tgt;
               fid_d   = 1'b1;
            end else if (bus.jumpEn_in) begin
               // bit1 set means a 2-byte aligned target: report, no redirect
               if (bus.jumpAddr_in[1]) begin
                  mis_d   = 1'b1;
                  maddr_d = bus.jumpAddr_in;
               end else begin
                  state_d = REDIR_PEND;
                  addr_d  = jump_tgt;
               end
            end
         end

         REDIR_PEND: begin
            // a trap either preempts or chains behind a completing handshake;
            // both end in PEND with the trap target
            if (bus.trapEn_in) begin
               state_d = REDIR_PEND;
               addr_d  = trap_tgt;
               fid_d   = 1'b1;
            end else if (hs) begin
               if (SHADOW_CYC == 0) begin
                  state_d = REDIR_IDLE;
               end else begin
                  state_d = REDIR_SHADOW;
                  cnt_d   = CW'(SHADOW_CYC - 1);
               end
            end
         end

         REDIR_SHADOW: begin
            if (bus.trapEn_in) begin
               state_d = REDIR_PEND;
               addr_d  = trap_tgt;
               fid_d   = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = REDIR_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = REDIR_IDLE;
         end
      endcase
   end

   assign bus.redirValid_out   = (state_q == REDIR_PEND);
   assign bus.redirAddr_out    = addr_q;
   assign bus.flushIF_out      = (state_q != REDIR_IDLE);
   assign bus.flushID_out      = fid_q;
   assign bus.idStall_out      = (state_q != REDIR_IDLE);
   assign bus.misalign_out     = mis_q;
   assign bus.misalignAddr_out = maddr_q;

endmodule
